// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT datapath: sizes, frame-sequencer states,
// complex-word helpers and the common twiddle table used by every butterfly stage.
package fft_pkg;

    localparam int FFT_N    = 16;
    localparam int FFT_DW   = 32;
    localparam int FFT_LOGN = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } frame_state_t;

    function automatic logic [FFT_DW-1:0] cplx_pack(input logic [15:0] re, input logic [15:0] im);
        return {re, im};
    endfunction

    function automatic logic [15:0] cplx_re(input logic [FFT_DW-1:0] w);
        return w[31:16];
    endfunction

    function automatic logic [15:0] cplx_im(input logic [FFT_DW-1:0] w);
        return w[15:0];
    endfunction

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.15, k = 0..7
    localparam logic [15:0] TW_RE [8] = '{16'h7FFF, 16'h7642, 16'h5A82, 16'h30FC,
                                          16'h0000, 16'hCF04, 16'hA57E, 16'h89BE};
    localparam logic [15:0] TW_IM [8] = '{16'h0000, 16'hCF04, 16'hA57E, 16'h89BE,
                                          16'h8001, 16'h89BE, 16'hA57E, 16'hCF04};

endpackage

// File: rtl/fft_bitrev.sv
// Bit-reverses a LOGN-bit index; used to emit results in natural frequency order.
module fft_bitrev #(
    parameter int LOGN = 4
) (
    input  logic [LOGN-1:0] idx,
    output logic [LOGN-1:0] rev
);

    for (genvar b = 0; b < LOGN; b++) begin : g_rev
        assign rev[b] = idx[LOGN-1-b];
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 16-point FFT: collects samples, runs the stage chain, drains results.
// Define FFT_FRAME_CTRL_BITREV_EN to emit results in bit-reversed (natural frequency) order.
//
//   state | meaning
//   FILL  | accepting serial samples into the frame buffer
//   RUN   | buffer held on stage1, waiting STAGE_LAT cycles, then capture res_bus
//   DRAIN | offering captured results under valid/ready
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N         = FFT_N,
    parameter int DW        = FFT_DW,
    parameter int STAGE_LAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [15:0]     in_data,
    output logic            in_ready,
    output logic [N*DW-1:0] buf_bus,
    output logic            stage_start,
    input  logic [N*DW-1:0] res_bus,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            frame_done
);

    localparam int CW = $clog2(N);
    localparam int WW = (STAGE_LAT > 0) ? $clog2(STAGE_LAT + 1) : 1;

    frame_state_t  state_q, state_d;
    logic [CW-1:0] wr_cnt, rd_cnt, rd_idx;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   buf_q [N];
    logic [DW-1:0] res_q [N];
    logic          done_q;
    logic          in_beat, out_beat, wait_done, wr_last, rd_last;

    assign wr_last   = (wr_cnt == CW'(N - 1));
    assign rd_last   = (rd_cnt == CW'(N - 1));
    assign in_beat   = (state_q == FILL) && in_valid;
    assign out_beat  = (state_q == DRAIN) && out_ready;
    assign wait_done = (state_q == RUN) && (wait_cnt == WW'(STAGE_LAT));

`ifdef FFT_FRAME_CTRL_BITREV_EN
    fft_bitrev #(.LOGN(CW)) u_bitrev (
        .idx (rd_cnt),
        .rev (rd_idx)
    );
`else
    assign rd_idx = rd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    // Handshake outputs decode registered state only, never in_valid/out_ready.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        stage_start = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_beat && wr_last) state_d = RUN;
            end
            RUN: begin
                stage_start = (wait_cnt == '0);
                if (wait_done) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = rd_last;
                if (out_beat && rd_last) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= out_beat && rd_last;
            if (in_beat)          wr_cnt   <= wr_last ? '0 : wr_cnt + CW'(1);
            if (out_beat)         rd_cnt   <= rd_last ? '0 : rd_cnt + CW'(1);
            if (state_q == RUN)   wait_cnt <= wait_done ? '0 : wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                buf_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            if (in_beat) buf_q[wr_cnt] <= in_data;
            if (wait_done) begin
                for (int k = 0; k < N; k++) res_q[k] <= res_bus[k*DW +: DW];
            end
        end
    end

    always_comb begin
        buf_bus = '0;
        for (int k = 0; k < N; k++) buf_bus[k*DW +: DW] = cplx_pack(buf_q[k], 16'h0000);
    end

    assign out_data   = out_valid ? res_q[rd_idx] : '0;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: frame-level scoreboard plus directed latency,
// backpressure, input-blocking and mid-drain reset scenarios.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

    localparam int N  = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            in_valid, in_ready, stage_start, out_valid, out_last, out_ready, frame_done;
    logic [15:0]     in_data;
    logic [N*DW-1:0] buf_bus, res_bus;
    logic [DW-1:0]   out_data;

    logic            l_in_valid, l_in_ready, l_stage_start, l_out_valid, l_out_last, l_out_ready, l_frame_done;
    logic [15:0]     l_in_data;
    logic [N*DW-1:0] l_buf_bus, l_res_bus;
    logic [DW-1:0]   l_out_data;
    logic [N*DW-1:0] l_pipe [3];

    fft_frame_ctrl #(.N(N), .DW(DW), .STAGE_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .buf_bus(buf_bus), .stage_start(stage_start), .res_bus(res_bus), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .frame_done(frame_done));

    fft_frame_ctrl #(.N(N), .DW(DW), .STAGE_LAT(3)) dut_lat (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_data(l_in_data), .in_ready(l_in_ready),
        .buf_bus(l_buf_bus), .stage_start(l_stage_start), .res_bus(l_res_bus), .out_valid(l_out_valid),
        .out_data(l_out_data), .out_last(l_out_last), .out_ready(l_out_ready), .frame_done(l_frame_done));

    // loopback stubs: combinational for the main DUT, three register stages for dut_lat
    assign res_bus = buf_bus;
    always @(posedge clk) begin
        l_pipe[0] <= l_buf_bus;
        l_pipe[1] <= l_pipe[0];
        l_pipe[2] <= l_pipe[1];
    end
    assign l_res_bus = l_pipe[2];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int ord(input int i);
        int r;
        r = i;
`ifdef FFT_FRAME_CTRL_BITREV_EN
        r = 0;
        for (int b = 0; b < 4; b++) if (((i >> b) & 1) != 0) r += (8 >> b);
`endif
        return r;
    endfunction

    // frame-level model: a frame of 16 accepted samples becomes 16 queued result words
    logic [DW-1:0]   q[$];
    logic [15:0]     acc[$];
    logic [DW-1:0]   log_q[$];
    logic [N*DW-1:0] frame_bus;
    int cyc = 0;
    int t_last = -100;
    int beat = 0;
    int dcnt = 0;
    int done_cyc = -1;
    int cap_cyc = -1;
    logic done_exp = 1'b0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : compare
        logic er, ev;
        if (!rst_n) begin
            q.delete();
            acc.delete();
            beat = 0;
            done_exp = 1'b0;
            prev_stall = 1'b0;
            t_last = -100;
        end else begin
            er = (q.size() == 0);
            ev = (q.size() != 0) && (cyc >= t_last + 2);
            chk("in_ready", in_ready, er);
            chk("stage_start", stage_start, (q.size() != 0) && (cyc == t_last + 1));
            chk("frame_done", frame_done, done_exp);
            chk("out_valid", out_valid, ev);
            chk("out_last", out_last, ev && (beat == N - 1));
            if (ev) chk("out_data", out_data, q[0]);
            if (prev_stall) chk("stall_hold", out_data, prev_data);
            if (q.size() != 0 && cyc > t_last) chk("buf_bus_hold", buf_bus, frame_bus);
            if (frame_done) begin
                dcnt++;
                done_cyc = cyc;
            end
            done_exp = 1'b0;
            prev_stall = ev && !out_ready;
            prev_data = out_data;
            if (ev && out_ready) begin
                log_q.push_back(q.pop_front());
                if (beat == N - 1) begin
                    beat = 0;
                    done_exp = 1'b1;
                end else beat++;
            end
            if (in_valid && er) begin
                if (acc.size() == 0) cap_cyc = cyc;
                acc.push_back(in_data);
                if (acc.size() == N) begin
                    for (int k = 0; k < N; k++) frame_bus[k*DW +: DW] = {acc[k], 16'h0000};
                    for (int k = 0; k < N; k++) q.push_back({acc[ord(k)], 16'h0000});
                    t_last = cyc;
                    acc.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int base, input int step);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(base + step * i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int i;
        i = 0;
        while (dcnt < target && i < 300) begin
            tick();
            i++;
        end
        if (dcnt < target) chk(name, 0, 1);
    endtask

    task automatic check_log(input string name, input int base, input int step);
        chk({name, "_count"}, log_q.size(), N);
        for (int k = 0; k < N && k < log_q.size(); k++)
            chk(name, log_q[k], {16'(base + step * ord(k)), 16'h0000});
    endtask

    initial begin : global_guard
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : stim
        int lit[16];
        int d0, T, first_st, first_ov, nst, beats, lat_done, i;
        logic [N*DW-1:0] snap, lat_frame;
        logic pat[4];

`ifdef FFT_FRAME_CTRL_BITREV_EN
        lit = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
        lit = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        // reset values
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_stage_start", stage_start, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_buf_bus", buf_bus, 0);
        chk("rst_lat_in_ready", l_in_ready, 1'b1);
        @(posedge clk); #1;

        // latency with STAGE_LAT=3
        T = -1;
        for (int k = 0; k < N; k++) begin
            l_in_data = 16'(k);
            l_in_valid = 1'b1;
            if (k == N - 1) T = cyc;
            tick();
        end
        l_in_valid = 1'b0;
        l_out_ready = 1'b1;
        for (int k = 0; k < N; k++) lat_frame[k*DW +: DW] = {16'(k), 16'h0000};
        first_st = -1; first_ov = -1; nst = 0; beats = 0; lat_done = -1; snap = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (l_stage_start) begin
                nst++;
                if (first_st < 0) first_st = cyc;
            end
            if (l_out_valid && first_ov < 0) begin
                first_ov = cyc;
                chk("lat_first_word", l_out_data, 0);
            end
            if (cyc == T + 1) begin
                snap = l_buf_bus;
                chk("lat_frame", l_buf_bus, lat_frame);
                chk("lat_in_ready_run", l_in_ready, 1'b0);
            end
            if (cyc > T + 1 && cyc <= T + 4) chk("lat_buf_hold", l_buf_bus, snap);
            if (l_out_valid && l_out_ready) begin
                beats++;
                if (beats == N) begin
                    chk("lat_last_flag", l_out_last, 1'b1);
                    chk("lat_last_word", l_out_data, 32'h000F0000);
                end
            end
            if (l_frame_done && lat_done < 0) lat_done = cyc;
            @(posedge clk); #1;
        end
        chk("lat_stage_start_cyc", first_st, T + 1);
        chk("lat_stage_start_cnt", nst, 1);
        chk("lat_out_valid_cyc", first_ov, T + 5);
        chk("lat_beats", beats, N);
        chk("lat_frame_done_cyc", lat_done, T + 21);

        // basic order, STAGE_LAT=0
        log_q.delete();
        out_ready = 1'b1;
        d0 = dcnt;
        feed(0, 1);
        wait_done(d0 + 1, "basic_timeout");
        chk("basic_count", log_q.size(), N);
        for (int k = 0; k < N && k < log_q.size(); k++) begin
            chk("basic_re", log_q[k][31:16], 16'(lit[k]));
            chk("basic_im", log_q[k][15:0], 16'h0000);
        end

        // backpressure 1,0,0,1 during drain
        log_q.delete();
        out_ready = 1'b1;
        d0 = dcnt;
        feed(1000, 37);
        i = 0;
        while (dcnt < d0 + 1 && i < 300) begin
            out_ready = pat[i % 4];
            tick();
            i++;
        end
        if (dcnt < d0 + 1) chk("bp_timeout", 0, 1);
        out_ready = 1'b1;
        check_log("bp_word", 1000, 37);

        // input blocking: in_valid held with 7FFF through RUN/DRAIN
        log_q.delete();
        d0 = dcnt;
        feed(200, 1);
        in_valid = 1'b1;
        in_data = 16'h7FFF;
        wait_done(d0 + 1, "blk_timeout");
        check_log("blk_word", 200, 1);
        chk("blk_capture_cyc", cap_cyc, done_cyc);
        log_q.delete();
        repeat (N - 1) tick();
        in_valid = 1'b0;
        wait_done(d0 + 2, "blk2_timeout");
        check_log("blk2_word", 16'h7FFF, 0);

        // reset mid-drain after the 5th beat
        log_q.delete();
        d0 = dcnt;
        feed(50, 2);
        i = 0;
        while (log_q.size() < 5 && i < 100) begin
            tick();
            i++;
        end
        chk("mid_beats_before_reset", log_q.size(), 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", in_ready, 1'b1);
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_out_last", out_last, 1'b0);
        chk("mid_frame_done", frame_done, 1'b0);
        chk("mid_out_data", out_data, 0);
        chk("mid_buf_bus", buf_bus, 0);
        @(posedge clk); #1;
        log_q.delete();
        d0 = dcnt;
        feed(300, 5);
        wait_done(d0 + 1, "mid_timeout");
        check_log("mid_word", 300, 5);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
